// File: rtl/async_fifo_rd_drain.sv
// async_fifo_rd_drain
// Read-domain consumer for the async FIFO. It issues FIFO reads, absorbs the
// FIFO's one-cycle registered read latency in a small skid buffer, and
// re-presents the words as a valid/ready stream at up to one word per clock.
// Optional statistics counters (rd_cnt_o, drop_cnt_o) are built only when
// ASYNC_FIFO_RD_DRAIN_STATS_EN is defined.
module async_fifo_rd_drain #(
  parameter int WIDTH      = 8,
  parameter int SKID_DEPTH = 2,
  parameter int OCC_WIDTH  = 2,
  parameter int CNT_WIDTH  = 16
) (
  input  logic                 clk_i,
  input  logic                 rst_n_i,
  input  logic                 en_i,
  input  logic                 flush_i,
  output logic                 rd_en_o,
  input  logic [WIDTH-1:0]     rdata_i,
  input  logic                 empty_i,
  input  logic                 rd_error_i,
  output logic                 m_valid_o,
  output logic [WIDTH-1:0]     m_data_o,
  input  logic                 m_ready_i,
  output logic [OCC_WIDTH-1:0] occ_o,
  output logic                 err_o,
  input  logic                 clr_err_i
`ifdef ASYNC_FIFO_RD_DRAIN_STATS_EN
  ,
  output logic [CNT_WIDTH-1:0] rd_cnt_o,
  output logic [CNT_WIDTH-1:0] drop_cnt_o
`endif
);

  localparam int IDX_W = (SKID_DEPTH > 1) ? $clog2(SKID_DEPTH) : 1;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2
  } state_t;

  state_t               state_q;
  state_t               state_d;
  logic [OCC_WIDTH-1:0] occ_q;
  logic                 infl_q;
  logic                 err_q;
  logic [IDX_W-1:0]     wr_idx_q;
  logic [IDX_W-1:0]     rd_idx_q;
  logic [WIDTH-1:0]     buf_q [SKID_DEPTH];

  logic                 pop;
  logic                 cap;
  logic                 drop_err;
  logic [OCC_WIDTH:0]   occ_ahead;

  // Buffer indices wrap at SKID_DEPTH, which need not be a power of two.
  function automatic logic [IDX_W-1:0] idx_inc(input logic [IDX_W-1:0] idx);
    if (idx == IDX_W'(SKID_DEPTH - 1)) return '0;
    return idx + IDX_W'(1);
  endfunction

  assign m_valid_o = (occ_q != '0);
  assign pop       = m_valid_o & m_ready_i;
  // A word arriving from the FIFO is kept only if it is good and not flushed.
  assign cap       = infl_q & ~rd_error_i & ~flush_i;
  assign drop_err  = infl_q & rd_error_i;
  // Words that will be held after this edge if the in-flight word lands.
  assign occ_ahead = {1'b0, occ_q} + {{OCC_WIDTH{1'b0}}, infl_q} - {{OCC_WIDTH{1'b0}}, pop};

  assign m_data_o  = m_valid_o ? buf_q[rd_idx_q] : '0;
  assign occ_o     = occ_q;
  assign err_o     = err_q;

  // Next-state and read-request decode; a read is only issued if its word is
  // guaranteed a free slot even when nothing is popped next cycle.
  always_comb begin
    state_d = state_q;
    rd_en_o = 1'b0;
    unique case (state_q)
      IDLE:    if (en_i) state_d = RUN;
      RUN:     if (!en_i) state_d = DRAIN;
      DRAIN: begin
        if (en_i) state_d = RUN;
        else if ((occ_q == '0) && !infl_q) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
    if ((state_q == RUN) && en_i && !empty_i && !flush_i &&
        (occ_ahead < (OCC_WIDTH + 1)'(SKID_DEPTH))) begin
      rd_en_o = 1'b1;
    end
  end

  // FSM state register; flush leaves the state alone.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) state_q <= IDLE;
    else          state_q <= state_d;
  end

  // Skid occupancy, buffer indices and in-flight read tracking.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      occ_q    <= '0;
      infl_q   <= 1'b0;
      wr_idx_q <= '0;
      rd_idx_q <= '0;
    end else begin
      infl_q <= rd_en_o;
      if (flush_i) begin
        occ_q    <= '0;
        wr_idx_q <= '0;
        rd_idx_q <= '0;
      end else begin
        occ_q <= occ_q + OCC_WIDTH'(cap) - OCC_WIDTH'(pop);
        if (cap) wr_idx_q <= idx_inc(wr_idx_q);
        if (pop) rd_idx_q <= idx_inc(rd_idx_q);
      end
    end
  end

  // Sticky underflow flag; a new error beats a simultaneous clear.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i)       err_q <= 1'b0;
    else if (drop_err)  err_q <= 1'b1;
    else if (clr_err_i) err_q <= 1'b0;
  end

  // Skid storage holds data only; occupancy decides what is valid.
  always_ff @(posedge clk_i) begin
    if (cap) buf_q[wr_idx_q] <= rdata_i;
  end

`ifdef ASYNC_FIFO_RD_DRAIN_STATS_EN
  logic [CNT_WIDTH-1:0] rd_cnt_q;
  logic [CNT_WIDTH-1:0] drop_cnt_q;
  logic [OCC_WIDTH:0]   drop_n;

  // A flush discards everything held plus any word landing this cycle,
  // minus a word the consumer takes on the same edge.
  assign drop_n = flush_i ? occ_ahead : {{OCC_WIDTH{1'b0}}, drop_err};

  // Delivered and discarded word counters, wrapping, cleared by reset only.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      rd_cnt_q   <= '0;
      drop_cnt_q <= '0;
    end else begin
      rd_cnt_q   <= rd_cnt_q + CNT_WIDTH'(pop);
      drop_cnt_q <= drop_cnt_q + CNT_WIDTH'(drop_n);
    end
  end

  assign rd_cnt_o   = rd_cnt_q;
  assign drop_cnt_o = drop_cnt_q;
`endif

endmodule

// File: tb/tb_async_fifo_rd_drain.sv
// Directed bench for async_fifo_rd_drain with a behavioural FIFO read port.
module tb_async_fifo_rd_drain;

  logic       clk_i     = 1'b0;
  logic       rst_n_i   = 1'b0;
  logic       en_i      = 1'b0;
  logic       flush_i   = 1'b0;
  logic       m_ready_i = 1'b0;
  logic       clr_err_i = 1'b0;
  logic       rd_en_o;
  logic [7:0] rdata_i;
  logic       empty_i;
  logic       rd_error_i;
  logic       m_valid_o;
  logic [7:0] m_data_o;
  logic [1:0] occ_o;
  logic       err_o;
`ifdef ASYNC_FIFO_RD_DRAIN_STATS_EN
  logic [15:0] rd_cnt_o;
  logic [15:0] drop_cnt_o;
`endif

  int n_cmp    = 0;
  int n_bad    = 0;
  int occ_viol = 0;

  // Behavioural FIFO: registered read data, per-entry forced error flag.
  logic [7:0] fmem [16];
  logic       ferr [16];
  logic [3:0] fwr = 4'd0;
  logic [3:0] frd;

  async_fifo_rd_drain dut (
    .clk_i      (clk_i),
    .rst_n_i    (rst_n_i),
    .en_i       (en_i),
    .flush_i    (flush_i),
    .rd_en_o    (rd_en_o),
    .rdata_i    (rdata_i),
    .empty_i    (empty_i),
    .rd_error_i (rd_error_i),
    .m_valid_o  (m_valid_o),
    .m_data_o   (m_data_o),
    .m_ready_i  (m_ready_i),
    .occ_o      (occ_o),
    .err_o      (err_o),
    .clr_err_i  (clr_err_i)
`ifdef ASYNC_FIFO_RD_DRAIN_STATS_EN
    ,
    .rd_cnt_o   (rd_cnt_o),
    .drop_cnt_o (drop_cnt_o)
`endif
  );

  always #5 clk_i = ~clk_i;

  assign empty_i = (fwr == frd);

  always @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      frd        <= fwr;
      rdata_i    <= 8'h00;
      rd_error_i <= 1'b0;
    end else if (rd_en_o) begin
      rdata_i    <= fmem[frd];
      rd_error_i <= ferr[frd];
      frd        <= frd + 4'd1;
    end else begin
      rd_error_i <= 1'b0;
    end
  end

  always @(negedge clk_i) begin
    if (rst_n_i && (occ_o > 2'd2)) occ_viol++;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic push(input logic [7:0] d, input logic e);
    fmem[fwr] = d;
    ferr[fwr] = e;
    fwr = fwr + 4'd1;
  endtask

  task automatic step;
    @(posedge clk_i); #1;
  endtask

  task automatic go_idle;
    en_i = 1'b0; m_ready_i = 1'b0;
    repeat (3) step();
  endtask

  task automatic test_reset;
    rst_n_i = 1'b0;
    repeat (3) @(posedge clk_i);
    @(negedge clk_i);
    n_cmp++; if (m_valid_o !== 1'b0) begin n_bad++; $display("FAIL reset_valid: got %b want 0", m_valid_o); end
    n_cmp++; if (rd_en_o !== 1'b0) begin n_bad++; $display("FAIL reset_rd_en: got %b want 0", rd_en_o); end
    n_cmp++; if (occ_o !== 2'd0) begin n_bad++; $display("FAIL reset_occ: got %0d want 0", occ_o); end
    n_cmp++; if (err_o !== 1'b0) begin n_bad++; $display("FAIL reset_err: got %b want 0", err_o); end
    n_cmp++; if (m_data_o !== 8'h00) begin n_bad++; $display("FAIL reset_data: got %h want 00", m_data_o); end
`ifdef ASYNC_FIFO_RD_DRAIN_STATS_EN
    n_cmp++; if (rd_cnt_o !== 16'd0) begin n_bad++; $display("FAIL reset_rd_cnt: got %0d want 0", rd_cnt_o); end
`endif
    step();
    rst_n_i = 1'b1;
    step();
  endtask

  task automatic test_burst;
    logic       exp_rd [7] = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
    logic       exp_v  [7] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0};
    logic [7:0] exp_d  [7] = '{8'h00, 8'h00, 8'h00, 8'h11, 8'h22, 8'h33, 8'h00};
    push(8'h11, 1'b0); push(8'h22, 1'b0); push(8'h33, 1'b0);
    en_i = 1'b1; m_ready_i = 1'b1;
    for (int c = 0; c < 7; c++) begin
      @(negedge clk_i);
      n_cmp++; if (rd_en_o !== exp_rd[c]) begin n_bad++; $display("FAIL burst_rd_en c%0d: got %b want %b", c, rd_en_o, exp_rd[c]); end
      n_cmp++; if (m_valid_o !== exp_v[c]) begin n_bad++; $display("FAIL burst_valid c%0d: got %b want %b", c, m_valid_o, exp_v[c]); end
      if (exp_v[c]) begin
        n_cmp++; if (m_data_o !== exp_d[c]) begin n_bad++; $display("FAIL burst_data c%0d: got %h want %h", c, m_data_o, exp_d[c]); end
      end
      step();
    end
  endtask

  task automatic test_backpressure;
    logic [7:0] w [5] = '{8'h51, 8'h52, 8'h53, 8'h54, 8'h55};
    int nrd = 0;
    go_idle();
    for (int i = 0; i < 5; i++) push(w[i], 1'b0);
    en_i = 1'b1; m_ready_i = 1'b0;
    for (int c = 0; c < 7; c++) begin
      @(negedge clk_i);
      if (rd_en_o === 1'b1) nrd++;
      if (c < 6) step();
    end
    n_cmp++; if (nrd != 2) begin n_bad++; $display("FAIL bp_reads: got %0d want 2", nrd); end
    n_cmp++; if (occ_o !== 2'd2) begin n_bad++; $display("FAIL bp_occ: got %0d want 2", occ_o); end
    n_cmp++; if (rd_en_o !== 1'b0) begin n_bad++; $display("FAIL bp_rd_en_full: got %b want 0", rd_en_o); end
    n_cmp++; if (m_data_o !== 8'h51) begin n_bad++; $display("FAIL bp_hold: got %h want 51", m_data_o); end
    step();
    m_ready_i = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk_i);
      n_cmp++; if (m_valid_o !== 1'b1 || m_data_o !== w[i]) begin n_bad++; $display("FAIL bp_stream %0d: got v=%b d=%h want v=1 d=%h", i, m_valid_o, m_data_o, w[i]); end
      step();
    end
    @(negedge clk_i);
    n_cmp++; if (m_valid_o !== 1'b0) begin n_bad++; $display("FAIL bp_end_valid: got %b want 0", m_valid_o); end
    step();
  endtask

  task automatic test_flush;
    logic [7:0] got [8];
    int ng = 0;
    go_idle();
    push(8'h61, 1'b0); push(8'h62, 1'b0); push(8'h63, 1'b0); push(8'h64, 1'b0);
    en_i = 1'b1; m_ready_i = 1'b0;
    repeat (3) step();
    flush_i = 1'b1;
    @(negedge clk_i);
    n_cmp++; if (occ_o !== 2'd1 || m_valid_o !== 1'b1) begin n_bad++; $display("FAIL flush_pre: got occ=%0d v=%b want occ=1 v=1", occ_o, m_valid_o); end
    n_cmp++; if (rd_en_o !== 1'b0) begin n_bad++; $display("FAIL flush_rd_en: got %b want 0", rd_en_o); end
    step();
    flush_i = 1'b0; m_ready_i = 1'b1;
    @(negedge clk_i);
    n_cmp++; if (m_valid_o !== 1'b0 || occ_o !== 2'd0) begin n_bad++; $display("FAIL flush_post: got v=%b occ=%0d want v=0 occ=0", m_valid_o, occ_o); end
    n_cmp++; if (dut.state_q !== 2'd1) begin n_bad++; $display("FAIL flush_state: got %0d want 1", dut.state_q); end
`ifdef ASYNC_FIFO_RD_DRAIN_STATS_EN
    n_cmp++; if (drop_cnt_o !== 16'd2) begin n_bad++; $display("FAIL flush_drop_cnt: got %0d want 2", drop_cnt_o); end
`endif
    step();
    for (int c = 0; c < 6; c++) begin
      @(negedge clk_i);
      if (m_valid_o && m_ready_i) begin if (ng < 8) got[ng] = m_data_o; ng++; end
      step();
    end
    n_cmp++; if (ng != 2) begin n_bad++; $display("FAIL flush_count: got %0d want 2", ng); end
    else begin
      n_cmp++; if (got[0] !== 8'h63 || got[1] !== 8'h64) begin n_bad++; $display("FAIL flush_order: got %h %h want 63 64", got[0], got[1]); end
    end
  endtask

  task automatic test_underflow;
    logic [7:0] got [8];
    int ng = 0;
    logic saw_aa = 1'b0;
    en_i = 1'b1; m_ready_i = 1'b1;
    push(8'h71, 1'b0); push(8'hAA, 1'b1); push(8'h72, 1'b0);
    for (int c = 0; c < 8; c++) begin
      @(negedge clk_i);
      if (m_valid_o && m_data_o === 8'hAA) saw_aa = 1'b1;
      if (m_valid_o && m_ready_i) begin if (ng < 8) got[ng] = m_data_o; ng++; end
      step();
    end
    n_cmp++; if (saw_aa !== 1'b0) begin n_bad++; $display("FAIL uf_bad_word: got 1 want 0"); end
    n_cmp++; if (ng != 2) begin n_bad++; $display("FAIL uf_count: got %0d want 2", ng); end
    else begin
      n_cmp++; if (got[0] !== 8'h71 || got[1] !== 8'h72) begin n_bad++; $display("FAIL uf_order: got %h %h want 71 72", got[0], got[1]); end
    end
    @(negedge clk_i);
    n_cmp++; if (err_o !== 1'b1) begin n_bad++; $display("FAIL uf_err_set: got %b want 1", err_o); end
    step();
    clr_err_i = 1'b1;
    step();
    clr_err_i = 1'b0;
    @(negedge clk_i);
    n_cmp++; if (err_o !== 1'b0) begin n_bad++; $display("FAIL uf_err_clr: got %b want 0", err_o); end
    step();
    push(8'hAB, 1'b1);
    step();
    clr_err_i = 1'b1;
    step();
    clr_err_i = 1'b0;
    @(negedge clk_i);
    n_cmp++; if (err_o !== 1'b1) begin n_bad++; $display("FAIL uf_err_wins: got %b want 1", err_o); end
`ifdef ASYNC_FIFO_RD_DRAIN_STATS_EN
    n_cmp++; if (drop_cnt_o !== 16'd4) begin n_bad++; $display("FAIL uf_drop_cnt: got %0d want 4", drop_cnt_o); end
    n_cmp++; if (rd_cnt_o !== 16'd12) begin n_bad++; $display("FAIL uf_rd_cnt: got %0d want 12", rd_cnt_o); end
`endif
    step();
  endtask

  task automatic test_drain;
    logic [7:0] got [8];
    int ng = 0;
    en_i = 1'b1; m_ready_i = 1'b0;
    push(8'h81, 1'b0); push(8'h82, 1'b0);
    repeat (3) step();
    @(negedge clk_i);
    n_cmp++; if (occ_o !== 2'd2) begin n_bad++; $display("FAIL drain_pre_occ: got %0d want 2", occ_o); end
    step();
    push(8'h83, 1'b0);
    en_i = 1'b0; m_ready_i = 1'b1;
    for (int c = 0; c < 6; c++) begin
      @(negedge clk_i);
      n_cmp++; if (rd_en_o !== 1'b0) begin n_bad++; $display("FAIL drain_rd_en c%0d: got %b want 0", c, rd_en_o); end
      if (m_valid_o && m_ready_i) begin if (ng < 8) got[ng] = m_data_o; ng++; end
      step();
    end
    n_cmp++; if (ng != 2) begin n_bad++; $display("FAIL drain_count: got %0d want 2", ng); end
    else begin
      n_cmp++; if (got[0] !== 8'h81 || got[1] !== 8'h82) begin n_bad++; $display("FAIL drain_order: got %h %h want 81 82", got[0], got[1]); end
    end
    n_cmp++; if (dut.state_q !== 2'd0) begin n_bad++; $display("FAIL drain_idle: got %0d want 0", dut.state_q); end
  endtask

  task automatic test_async_reset;
    m_ready_i = 1'b0;
    push(8'h91, 1'b0); push(8'h92, 1'b0);
    en_i = 1'b1;
    repeat (3) step();
    #2;
    n_cmp++; if (m_valid_o !== 1'b1 || err_o !== 1'b1) begin n_bad++; $display("FAIL ar_pre: got v=%b err=%b want v=1 err=1", m_valid_o, err_o); end
    rst_n_i = 1'b0;
    #1;
    n_cmp++; if (m_valid_o !== 1'b0) begin n_bad++; $display("FAIL ar_valid: got %b want 0", m_valid_o); end
    n_cmp++; if (rd_en_o !== 1'b0) begin n_bad++; $display("FAIL ar_rd_en: got %b want 0", rd_en_o); end
    n_cmp++; if (occ_o !== 2'd0) begin n_bad++; $display("FAIL ar_occ: got %0d want 0", occ_o); end
    n_cmp++; if (err_o !== 1'b0) begin n_bad++; $display("FAIL ar_err: got %b want 0", err_o); end
`ifdef ASYNC_FIFO_RD_DRAIN_STATS_EN
    n_cmp++; if (rd_cnt_o !== 16'd0 || drop_cnt_o !== 16'd0) begin n_bad++; $display("FAIL ar_cnts: got %0d %0d want 0 0", rd_cnt_o, drop_cnt_o); end
`endif
    @(posedge clk_i); #2;
    rst_n_i = 1'b1;
    m_ready_i = 1'b1;
    step();
    for (int c = 0; c < 5; c++) begin
      @(negedge clk_i);
      n_cmp++; if (m_valid_o !== 1'b0) begin n_bad++; $display("FAIL ar_stale c%0d: got v=%b d=%h want v=0", c, m_valid_o, m_data_o); end
      step();
    end
  endtask

  initial begin
    test_reset();
    test_burst();
    test_backpressure();
    test_flush();
    test_underflow();
    test_drain();
    test_async_reset();
    n_cmp++; if (occ_viol !== 0) begin n_bad++; $display("FAIL occ_bound: got %0d cycles above 2 want 0", occ_viol); end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
